hcu_round_ctrl: RTL

- Sequencer for the SHA-2 hash compute unit (HCU) compression datapath: the working-variable registers a..h, the Ch/Majority/Sigma logic and the K constant ROM.
- Accepts one block-hash command, loads the working variables from the current digest, and steps the datapath once per accepted message word W_t.
- Issues a final digest-accumulate pulse, then holds the result valid until downstream accepts it.
- Supports SHA-256 (64 rounds) and SHA-512 (80 rounds), selected per command.

---
 rtl/hcu_round_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/hcu_round_ctrl.sv
// Round sequencer for the SHA-2 compression datapath: loads a..h, steps one
// round per accepted W_t, accumulates the digest and holds it for downstream.
module hcu_round_ctrl #(
    parameter int unsigned ROUNDS_256 = 64,
    parameter int unsigned ROUNDS_512 = 80,
    parameter int unsigned IDX_WIDTH  = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic                 start_sha512,
    input  logic                 abort,
    input  logic                 w_valid,
    output logic                 w_ready,
    output logic                 load_iv,
    output logic                 round_en,
    output logic [IDX_WIDTH-1:0] round_idx,
    output logic                 sha512_mode,
    output logic                 add_digest,
    output logic                 digest_valid,
    input  logic                 digest_ready,
    output logic                 busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                 mode_q, mode_d;
    logic [IDX_WIDTH-1:0] last_idx;

    assign last_idx    = mode_q ? IDX_WIDTH'(ROUNDS_512 - 1) : IDX_WIDTH'(ROUNDS_256 - 1);
    assign round_idx   = idx_q;
    assign sha512_mode = mode_q;

    // State, round index and latched mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state and state-decoded datapath controls
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        mode_d       = mode_q;
        start_ready  = 1'b0;
        w_ready      = 1'b0;
        load_iv      = 1'b0;
        round_en     = 1'b0;
        add_digest   = 1'b0;
        digest_valid = 1'b0;
        busy         = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy        = 1'b0;
                start_ready = 1'b1;
                if (start_valid) begin
                    mode_d  = start_sha512;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                load_iv = 1'b1;
                state_d = S_ROUND;
            end
            S_ROUND: begin
                // abort wins over a pending word so the datapath never advances
                if (!abort) begin
                    w_ready  = 1'b1;
                    round_en = w_valid;
                    if (w_valid) begin
                        if (idx_q == last_idx) begin
                            idx_d   = '0;
                            state_d = S_FINAL;
                        end else begin
                            idx_d = idx_q + IDX_WIDTH'(1);
                        end
                    end
                end
            end
            S_FINAL: begin
                add_digest = 1'b1;
                state_d    = S_DONE;
            end
            S_DONE: begin
                digest_valid = 1'b1;
                if (digest_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        if (abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            mode_d  = mode_q;
        end
    end

endmodule
